// File: rtl/fetch_fd_stage_pkg.sv
// Shared pipeline definitions: next-PC select encodings, reset PC and the nop word.
package fetch_fd_stage_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_J   = 2'b01,
        NPC_BR  = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/fetch_fd_stage_npc.sv
// Purely combinational next-PC selection driven by the instruction sitting in D.
module npc_unit
    import fetch_fd_stage_pkg::*;
(
    input  logic [1:0]  npc_op,
    input  logic        cmp_true,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [25:0] instr_idx,
    input  logic [31:0] rs_fwd_d,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    always_comb begin
        seq_pc = pc_f + 32'd4;
        // Branch offset is relative to the delay-slot address, i.e. pc_d + 4.
        br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
        br_pc  = pc_d + 32'd4 + br_off;
        j_pc   = {pc_d[31:28], instr_idx, 2'b00};

        npc = seq_pc;
        case (npc_op_e'(npc_op))
            NPC_SEQ: npc = seq_pc;
            NPC_J:   npc = j_pc;
            NPC_BR:  npc = cmp_true ? br_pc : seq_pc;
            NPC_JR:  npc = rs_fwd_d;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_fd_stage.sv
// Fetch PC register and F/D pipeline register; the delay slot is architectural so there is no flush.
module fetch_fd_stage
    import fetch_fd_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = fetch_fd_stage_pkg::PC_RESET,
    parameter int          IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       npc_op,
    input  logic             cmp_true,
    input  logic [31:0]      rs_fwd_d,
    input  logic [31:0]      instr_f,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d
);

    logic [31:0] pcf_q,   pcf_d;
    logic [31:0] instr_fd_q, instr_fd_d;
    logic [31:0] pc_fd_q, pc_fd_d;
    logic [31:0] npc;

    npc_unit u_npc (
        .npc_op    (npc_op),
        .cmp_true  (cmp_true),
        .pc_f      (pcf_q),
        .pc_d      (pc_fd_q),
        .instr_idx (instr_fd_q[25:0]),
        .rs_fwd_d  (rs_fwd_d),
        .npc       (npc)
    );

    // A stalled cycle discards the mux result, so a pending redirect lands on the first free edge.
    always_comb begin
        pcf_d      = pcf_q;
        instr_fd_d = instr_fd_q;
        pc_fd_d    = pc_fd_q;
        if (!stall) begin
            pcf_d      = npc;
            instr_fd_d = instr_f;
            pc_fd_d    = pcf_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcf_q      <= PC_RESET;
            instr_fd_q <= NOP;
            pc_fd_q    <= PC_RESET;
        end else begin
            pcf_q      <= pcf_d;
            instr_fd_q <= instr_fd_d;
            pc_fd_q    <= pc_fd_d;
        end
    end

    // Word address relative to the memory base; bits [1:0] of the PC are dropped.
    assign im_addr = IM_AW'((pcf_q - PC_RESET) >> 2);
    assign pc_f    = pcf_q;
    assign instr_d = instr_fd_q;
    assign pc_d    = pc_fd_q;
    assign pc8_d   = pc_fd_q + 32'd8;

endmodule
